iss_run_ctrl: RTL and testbench

//  Run/termination sequencer for the RISCV64G ISS testbench. Gates ISS execution with a run enable,

---
 rtl/iss_run_ctrl.sv | 110 +++++++++++
 tb/tb_iss_run_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iss_run_ctrl.sv
// Run/termination sequencer for the RISCV64G ISS bench: IDLE -> RUN -> DRAIN -> DONE.
// Optional console decode of tohost writes is enabled by defining LEVE_ISS_CONSOLE_EN.
module iss_run_ctrl #(
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned DRAIN_CYCLES   = 4
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             start,
   input  logic             tohost_we,
   input  logic [31:0]      tohost,
   output logic             run,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [30:0]      exit_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             console_valid,
   output logic [7:0]       console_char
);

   localparam int unsigned      DRN_W   = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t           state;
   logic [DRN_W-1:0] drain_cnt;
   logic             exit_wr;
   logic             wd_fire;

   always_comb begin
      exit_wr = tohost_we && tohost[0];
      wd_fire = (TIMEOUT_CYCLES != 0) && (cycle_cnt == WD_LAST);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= ST_IDLE;
         run       <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         exit_code <= '0;
         cycle_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  run       <= 1'b1;
                  cycle_cnt <= '0;
               end
            end
            ST_RUN: begin
               if (cycle_cnt != '1)
                  cycle_cnt <= cycle_cnt + 1'b1;
               // exit write takes priority over a watchdog expiring in the same cycle
               if (exit_wr) begin
                  exit_code <= tohost[31:1];
                  timeout   <= 1'b0;
                  run       <= 1'b0;
                  drain_cnt <= DRN_W'(DRAIN_CYCLES);
                  state     <= ST_DRAIN;
               end else if (wd_fire) begin
                  exit_code <= '0;
                  timeout   <= 1'b1;
                  run       <= 1'b0;
                  drain_cnt <= DRN_W'(DRAIN_CYCLES);
                  state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRN_W'(1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= !timeout && (exit_code == '0);
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LEVE_ISS_CONSOLE_EN
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         console_valid <= 1'b0;
         console_char  <= '0;
      end else begin
         console_valid <= 1'b0;
         if (state == ST_RUN && tohost_we && !tohost[0] && tohost[31:24] == 8'h01) begin
            console_valid <= 1'b1;
            console_char  <= tohost[7:0];
         end
      end
   end
`else
   always_comb begin
      console_valid = 1'b0;
      console_char  = '0;
   end
`endif

endmodule

// File: tb/tb_iss_run_ctrl.sv
// Bench for iss_run_ctrl: three configurations driven in parallel, checked each cycle
// against an outcome model derived from the first exit write and the watchdog limit.
module tb_iss_run_ctrl;

   localparam int NI  = 3;
   localparam int INF = 1 << 24;

   localparam int unsigned A_T = 1000000, A_D = 4;
   localparam int unsigned B_T = 16,      B_D = 4;
   localparam int unsigned C_T = 0,       C_D = 1;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        start = 1'b0;
   logic        tohost_we = 1'b0;
   logic [31:0] tohost = '0;

   logic        run_o [NI];
   logic        done_o[NI];
   logic        pass_o[NI];
   logic        to_o  [NI];
   logic        cv_o  [NI];
   logic [30:0] code_o[NI];
   logic [7:0]  cc_o  [NI];
   logic [31:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned t_cfg[NI];
   int unsigned d_cfg[NI];
   longint      cmax [NI];
   logic        cons_exp [NI];
   logic [7:0]  char_exp [NI];

   always #5 CLK = ~CLK;

   iss_run_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(A_T), .DRAIN_CYCLES(A_D)) u_a (
      .CLK(CLK), .RSTn(RSTn), .start(start), .tohost_we(tohost_we), .tohost(tohost),
      .run(run_o[0]), .done(done_o[0]), .pass(pass_o[0]), .timeout(to_o[0]),
      .exit_code(code_o[0]), .cycle_cnt(cnt_a), .console_valid(cv_o[0]), .console_char(cc_o[0]));

   iss_run_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(B_T), .DRAIN_CYCLES(B_D)) u_b (
      .CLK(CLK), .RSTn(RSTn), .start(start), .tohost_we(tohost_we), .tohost(tohost),
      .run(run_o[1]), .done(done_o[1]), .pass(pass_o[1]), .timeout(to_o[1]),
      .exit_code(code_o[1]), .cycle_cnt(cnt_b), .console_valid(cv_o[1]), .console_char(cc_o[1]));

   iss_run_ctrl #(.CNT_W(4), .TIMEOUT_CYCLES(C_T), .DRAIN_CYCLES(C_D)) u_c (
      .CLK(CLK), .RSTn(RSTn), .start(start), .tohost_we(tohost_we), .tohost(tohost),
      .run(run_o[2]), .done(done_o[2]), .pass(pass_o[2]), .timeout(to_o[2]),
      .exit_code(code_o[2]), .cycle_cnt(cnt_c), .console_valid(cv_o[2]), .console_char(cc_o[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_cnt(input int i);
      if (i == 0) return cnt_a;
      if (i == 1) return cnt_b;
      return {28'd0, cnt_c};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Outcome of a run: ends at RUN cycle e, by watchdog if the limit comes before any exit write.
   function automatic bit timed_out(input int i, input int w);
      return (t_cfg[i] != 0) && (w == 0 || w > int'(t_cfg[i]));
   endfunction

   function automatic int end_cycle(input int i, input int w);
      if (timed_out(i, w)) return int'(t_cfg[i]);
      return (w == 0) ? INF : w;
   endfunction

   task automatic check_all(input int kk, input int w, input logic [31:0] code);
      for (int i = 0; i < NI; i++) begin
         bit     tmo;
         int     e;
         longint ecnt;
         bit     edone;
         tmo   = timed_out(i, w);
         e     = end_cycle(i, w);
         edone = kk >= e + int'(d_cfg[i]);
         ecnt  = (kk < e) ? kk : e;
         if (ecnt > cmax[i]) ecnt = cmax[i];
         check($sformatf("run[%0d]@%0d", i, kk), 64'(run_o[i]), 64'(kk < e));
         check($sformatf("done[%0d]@%0d", i, kk), 64'(done_o[i]), 64'(edone));
         check($sformatf("cnt[%0d]@%0d", i, kk), 64'(get_cnt(i)), 64'(ecnt));
         check($sformatf("timeout[%0d]@%0d", i, kk), 64'(to_o[i]), 64'(kk >= e && tmo));
         check($sformatf("exit_code[%0d]@%0d", i, kk), 64'(code_o[i]),
               (kk >= e && !tmo) ? 64'(code[31:1]) : 64'd0);
         check($sformatf("pass[%0d]@%0d", i, kk), 64'(pass_o[i]),
               64'(edone && !tmo && code[31:1] == 31'd0));
         check($sformatf("cons_valid[%0d]@%0d", i, kk), 64'(cv_o[i]), 64'(cons_exp[i]));
         check($sformatf("cons_char[%0d]@%0d", i, kk), 64'(cc_o[i]), 64'(char_exp[i]));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s run[%0d]", tag, i), 64'(run_o[i]), 64'd0);
         check($sformatf("%s done[%0d]", tag, i), 64'(done_o[i]), 64'd0);
         check($sformatf("%s pass[%0d]", tag, i), 64'(pass_o[i]), 64'd0);
         check($sformatf("%s timeout[%0d]", tag, i), 64'(to_o[i]), 64'd0);
         check($sformatf("%s exit_code[%0d]", tag, i), 64'(code_o[i]), 64'd0);
         check($sformatf("%s cnt[%0d]", tag, i), 64'(get_cnt(i)), 64'd0);
         check($sformatf("%s cons_valid[%0d]", tag, i), 64'(cv_o[i]), 64'd0);
         check($sformatf("%s cons_char[%0d]", tag, i), 64'(cc_o[i]), 64'd0);
      end
   endtask

   task automatic do_reset();
      RSTn      = 1'b0;
      start     = 1'b0;
      tohost_we = 1'b0;
      tohost    = '0;
      repeat (2) tick();
      RSTn = 1'b1;
      for (int i = 0; i < NI; i++) begin
         cons_exp[i] = 1'b0;
         char_exp[i] = '0;
      end
   endtask

   // w = RUN cycle (1-based) of the first exit write, 0 for none; abort_k > 0 pulls reset then.
   task automatic do_run(input int w, input logic [31:0] code, input int len, input int abort_k);
      logic cw;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_all(0, w, code);
      for (int k = 0; k < len; k++) begin
         tohost_we = 1'b0;
         tohost    = '0;
         start     = ($urandom_range(0, 5) == 0);
         if (w != 0 && k + 1 == w) begin
            tohost_we = 1'b1;
            tohost    = code;
         end else if (w != 0 && k + 1 > w) begin
            tohost_we = 1'($urandom_range(0, 1));
            tohost    = $urandom;
         end else if (k == 1) begin
            tohost_we = 1'b1;
            tohost    = 32'h0100_0048;
         end else if (k == 2) begin
            tohost_we = 1'b1;
            tohost    = 32'h0100_0068;
         end else if ($urandom_range(0, 2) == 0) begin
            tohost_we = 1'b1;
            tohost    = ($urandom_range(0, 1) == 1) ? {8'h01, 16'($urandom), 8'($urandom)} : $urandom;
            tohost[0] = 1'b0;
         end
         cw = tohost_we && !tohost[0] && tohost[31:24] == 8'h01;
         for (int i = 0; i < NI; i++) begin
`ifdef LEVE_ISS_CONSOLE_EN
            cons_exp[i] = cw && (k < end_cycle(i, w));
            if (cons_exp[i]) char_exp[i] = tohost[7:0];
`else
            cons_exp[i] = 1'b0;
            if (cw) char_exp[i] = '0;
`endif
         end
         tick();
         if (k + 1 == abort_k) begin
            #2;
            RSTn = 1'b0;
            #1;
            check_zero($sformatf("abort@%0d", k + 1));
            tick();
            check_zero("abort_hold");
            return;
         end
         check_all(k + 1, w, code);
      end
      start     = 1'b0;
      tohost_we = 1'b0;
   endtask

   initial begin
      int          w;
      logic [31:0] code;
      t_cfg = '{A_T, B_T, C_T};
      d_cfg = '{A_D, B_D, C_D};
      cmax  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};

      do_reset();
      check_zero("reset");
      for (int k = 0; k < 100; k++) begin
         tohost_we = 1'($urandom_range(0, 1));
         tohost    = $urandom;
         tick();
         if (k % 25 == 24) check_zero($sformatf("idle@%0d", k));
      end
      tohost_we = 1'b0;

      do_run(50, 32'h0000_0001, 60, 0);
      do_run(30, 32'h0000_0007, 40, 0);
      do_run(0,  32'h0000_0000, 40, 0);
      do_run(16, 32'h0000_0001, 30, 0);
      do_run(17, 32'h0000_0003, 30, 0);
      do_run(15, 32'h0000_0001, 30, 0);
      do_run(1,  32'h0000_0001, 10, 0);
      do_run(10, 32'h0000_0005, 20, 10);
      do_run(12, 32'h0000_0001, 20, 0);

      repeat (6) begin
         w    = int'($urandom_range(1, 45));
         code = ($urandom_range(0, 2) == 0) ? 32'h1 : ($urandom | 32'h1);
         do_run(w, code, w + 8, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
